mcp4811_ctrl: RTL and testbench

- SPI master and update sequencer for the MCP48x1 single-channel DAC, which sets the TGC gain level.
- Accepts one DAC code per valid/ready handshake and serialises it as a 16-bit write frame.
- After the frame it pulses LDAC low, so the DAC output updates at a deterministic cycle.
- Sits between the gain-curve sequencer (upstream) and the DAC pins (downstream).

---
 rtl/mcp4811_ctrl_if.sv | 14 +
 rtl/mcp4811_ctrl.sv | 156 +++++++++++++++
 tb/tb_mcp4811_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcp4811_ctrl_if.sv
// Request channel between the gain-curve sequencer and the MCP48x1 DAC controller.
// The master side supplies the code and the shutdown flag; the slave side returns ready.
`timescale 1ns/1ps
interface mcp4811_ctrl_if #(
    parameter int DAC_DATA_W = 10
) ();
    logic [DAC_DATA_W-1:0] dac_data;
    logic                  dac_shdn;
    logic                  dac_valid;
    logic                  dac_ready;

    modport master (output dac_data, dac_shdn, dac_valid, input dac_ready);
    modport slave  (input dac_data, dac_shdn, dac_valid, output dac_ready);
endinterface

// File: rtl/mcp4811_ctrl.sv
// SPI master and LDAC update sequencer for the MCP4801/4811/4821 DAC (TGC gain level).
// One DAC code per handshake is sent as a 16-bit write frame, followed by an LDAC pulse.
//
// state | meaning
// IDLE  | ready for a request, cs_n high, sck low
// SHIFT | cs_n low, 16 bits shifted MSB first, 2*SCK_DIV clk per bit
// HOLD  | cs_n still low, sck low, sdi back to 0 for SCK_DIV clk
// GAP   | cs_n high for SCK_DIV clk before the update strobe
// LDAC  | ld_n low for LDAC_W clk, frame counter bumps on the last one
`timescale 1ns/1ps
module mcp4811_ctrl #(
    parameter int DAC_DATA_W = 10,
    parameter int SCK_DIV    = 2,
    parameter int LDAC_W     = 2,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    mcp4811_ctrl_if.slave     dac_if,
    output logic              busy_o,
    output logic              spi_cs_n_o,
    output logic              spi_sck_o,
    output logic              spi_sdi_o,
    output logic              dac_ld_n_o,
    output logic [CNT_W-1:0]  frame_cnt_o
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SHIFT = 3'd1;
    localparam logic [2:0] HOLD  = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
    localparam logic [2:0] LDAC  = 3'd4;

    localparam int         TMR_W    = 16;
    localparam logic [TMR_W-1:0] SCK_RLD  = TMR_W'(SCK_DIV - 1);
    localparam logic [TMR_W-1:0] LDAC_RLD = TMR_W'(LDAC_W - 1);

    logic [2:0]       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [3:0]       bit_q, bit_d;
    logic [15:0]      shreg_q, shreg_d;
    logic             cs_n_q, cs_n_d;
    logic             sck_q, sck_d;
    logic             sdi_q, sdi_d;
    logic             ld_n_q, ld_n_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      frame;
    logic             tc;

    always_comb begin
        // write, gain x1, active unless shutdown, code left-aligned in the 12-bit field
        frame = 16'h2000 | {3'b000, ~dac_if.dac_shdn, 12'h000}
              | (16'(dac_if.dac_data) << (12 - DAC_DATA_W));
        tc       = (tmr_q == '0);
        state_d  = state_q;
        tmr_d    = tc ? tmr_q : tmr_q - 1'b1;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        cs_n_d   = cs_n_q;
        sck_d    = sck_q;
        sdi_d    = sdi_q;
        ld_n_d   = ld_n_q;
        ready_d  = ready_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (dac_if.dac_valid && ready_q) begin
                    state_d = SHIFT;
                    ready_d = 1'b0;
                    cs_n_d  = 1'b0;
                    sck_d   = 1'b0;
                    sdi_d   = frame[15];
                    shreg_d = {frame[14:0], 1'b0};
                    bit_d   = 4'd15;
                    tmr_d   = SCK_RLD;
                end
            end
            SHIFT: begin
                if (tc) begin
                    tmr_d = SCK_RLD;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // sdi only moves on the falling sck, so it is stable at every rise
                        sck_d = 1'b0;
                        if (bit_q == 4'd0) begin
                            state_d = HOLD;
                            sdi_d   = 1'b0;
                        end else begin
                            bit_d   = bit_q - 4'd1;
                            sdi_d   = shreg_q[15];
                            shreg_d = {shreg_q[14:0], 1'b0};
                        end
                    end
                end
            end
            HOLD: begin
                if (tc) begin
                    state_d = GAP;
                    cs_n_d  = 1'b1;
                    tmr_d   = SCK_RLD;
                end
            end
            GAP: begin
                if (tc) begin
                    state_d = LDAC;
                    ld_n_d  = 1'b0;
                    tmr_d   = LDAC_RLD;
                end
            end
            LDAC: begin
                if (tc) begin
                    state_d = IDLE;
                    ld_n_d  = 1'b1;
                    ready_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
            ld_n_q  <= 1'b1;
            ready_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            sdi_q   <= sdi_d;
            ld_n_q  <= ld_n_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dac_if.dac_ready = ready_q;
    assign busy_o           = ~ready_q;
    assign spi_cs_n_o       = cs_n_q;
    assign spi_sck_o        = sck_q;
    assign spi_sdi_o        = sdi_q;
    assign dac_ld_n_o       = ld_n_q;
    assign frame_cnt_o      = cnt_q;
endmodule

// File: tb/tb_mcp4811_ctrl.sv
// Bench for mcp4811_ctrl: a default instance (10-bit, SCK_DIV=2, LDAC_W=2) and a fast
// 12-bit instance (SCK_DIV=1, LDAC_W=1, CNT_W=4), each with an SPI decoder and DAC model.
`timescale 1ns/1ps
module tb_mcp4811_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    mcp4811_ctrl_if #(.DAC_DATA_W(10)) if_a ();
    mcp4811_ctrl_if #(.DAC_DATA_W(12)) if_b ();

    logic        busy_a, cs_a, sck_a, sdi_a, ld_a;
    logic [15:0] fc_a;
    logic        busy_b, cs_b, sck_b, sdi_b, ld_b;
    logic [3:0]  fc_b;

    mcp4811_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .dac_if(if_a.slave), .busy_o(busy_a),
        .spi_cs_n_o(cs_a), .spi_sck_o(sck_a), .spi_sdi_o(sdi_a),
        .dac_ld_n_o(ld_a), .frame_cnt_o(fc_a)
    );

    mcp4811_ctrl #(.DAC_DATA_W(12), .SCK_DIV(1), .LDAC_W(1), .CNT_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .dac_if(if_b.slave), .busy_o(busy_b),
        .spi_cs_n_o(cs_b), .spi_sck_o(sck_b), .spi_sdi_o(sdi_b),
        .dac_ld_n_o(ld_b), .frame_cnt_o(fc_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SPI decoder, scoreboard and DAC register model per instance
    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int W = (g == 0) ? 10 : 12;
        wire cs  = (g == 0) ? cs_a  : cs_b;
        wire sck = (g == 0) ? sck_a : sck_b;
        wire sdi = (g == 0) ? sdi_a : sdi_b;
        wire ld  = (g == 0) ? ld_a  : ld_b;
        logic [15:0] exp_q [$];
        logic [15:0] sh          = '0;
        logic [15:0] in_reg      = '0;
        logic [11:0] dac_out     = '0;
        logic        dac_shdn_st = 1'b0;
        int          nb          = 0;
        int          ld_pulses   = 0;

        always @(negedge cs) begin
            nb = 0;
            sh = '0;
        end
        always @(posedge sck) begin
            chk("sck_rise_with_cs_low", 32'(cs), 32'd0);
            sh = {sh[14:0], sdi};
            nb++;
        end
        always @(posedge cs) begin
            if (rst_n === 1'b1) begin
                chk("sck_rises_per_frame", 32'(nb), 32'd16);
                if (exp_q.size() == 0) chk("unexpected_frame", 32'(sh), 32'hFFFF_FFFF);
                else chk("frame_word", 32'(sh), 32'(exp_q.pop_front()));
                in_reg = sh;
            end else if (exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
        end
        always @(negedge ld) begin
            ld_pulses++;
            dac_shdn_st = ~in_reg[12];
            dac_out     = (W == 10) ? {2'b00, in_reg[11:2]} : in_reg[11:0];
        end
    end

    function automatic logic cs_of(input int sel);  return sel != 0 ? cs_b  : cs_a;  endfunction
    function automatic logic sck_of(input int sel); return sel != 0 ? sck_b : sck_a; endfunction
    function automatic logic ld_of(input int sel);  return sel != 0 ? ld_b  : ld_a;  endfunction
    function automatic logic rdy_of(input int sel);
        return sel != 0 ? if_b.dac_ready : if_a.dac_ready;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic [11:0] d, input logic s, input logic v);
        if (sel == 0) begin
            if_a.dac_data = d[9:0]; if_a.dac_shdn = s; if_a.dac_valid = v;
        end else begin
            if_b.dac_data = d;      if_b.dac_shdn = s; if_b.dac_valid = v;
        end
    endtask

    task automatic push_exp(input int sel, input logic [15:0] w);
        if (sel == 0) g_mon[0].exp_q.push_back(w);
        else          g_mon[1].exp_q.push_back(w);
    endtask

    task automatic wait_ready(input int sel, input int limit);
        int n = 0;
        while (!rdy_of(sel) && n < limit) begin
            step();
            n++;
        end
        chk("ready_within_budget", 32'(rdy_of(sel)), 32'd1);
    endtask

    // Issues one request from an idle point and times every pin against T0
    task automatic timed_frame(input int sel, input logic [11:0] d, input logic s,
                               input logic [15:0] exp_w, input int dv, input int lw);
        int   cs_last = -1, ld_first = -1, ld_last = -1, rdy_first = -1;
        int   rises = 0, hi_run = 0, hi_max = 0;
        logic sck_prev = 1'b0;
        push_exp(sel, exp_w);
        drive(sel, d, s, 1'b1);
        step();
        drive(sel, d, s, 1'b0);
        chk("cs_low_at_T1", 32'(cs_of(sel)), 32'd0);
        chk("ready_low_at_T1", 32'(rdy_of(sel)), 32'd0);
        for (int t = 1; t <= 34*dv + lw + 4; t++) begin
            if (t > 1) step();
            if (!cs_of(sel)) cs_last = t;
            if (!ld_of(sel)) begin
                if (ld_first < 0) ld_first = t;
                ld_last = t;
            end
            if (rdy_of(sel) && rdy_first < 0) rdy_first = t;
            if (sck_of(sel)) begin
                hi_run++;
                if (hi_run > hi_max) hi_max = hi_run;
                if (!sck_prev) rises++;
            end else begin
                hi_run = 0;
            end
            sck_prev = sck_of(sel);
        end
        chk("cs_last_low_cycle", 32'(cs_last), 32'(33*dv));
        chk("ld_first_low_cycle", 32'(ld_first), 32'(34*dv + 1));
        chk("ld_last_low_cycle", 32'(ld_last), 32'(34*dv + lw));
        chk("ready_return_cycle", 32'(rdy_first), 32'(34*dv + lw + 1));
        chk("sck_high_time", 32'(hi_max), 32'(dv));
        chk("sck_rise_count", 32'(rises), 32'd16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int          t, lp0, fc0;
        logic [11:0] d;
        drive(0, 12'h000, 1'b0, 1'b0);
        drive(1, 12'h000, 1'b0, 1'b0);
        repeat (3) step();
        chk("rst_cs_n", 32'(cs_a), 32'd1);
        chk("rst_sck", 32'(sck_a), 32'd0);
        chk("rst_sdi", 32'(sdi_a), 32'd0);
        chk("rst_ld_n", 32'(ld_a), 32'd1);
        chk("rst_ready", 32'(if_a.dac_ready), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_frame_cnt", 32'(fc_a), 32'd0);
        chk("rst_b_cs_n", 32'(cs_b), 32'd1);
        rst_n = 1'b1;
        repeat (2) step();

        // default instance, 0x2A5 active
        timed_frame(0, 12'h2A5, 1'b0, 16'h3A94, 2, 2);
        chk("a_frame_cnt_1", 32'(fc_a), 32'd1);
        chk("a_dac_out_2a5", 32'(g_mon[0].dac_out), 32'h2A5);
        chk("a_dac_active", 32'(g_mon[0].dac_shdn_st), 32'd0);
        chk("a_busy_idle", 32'(busy_a), 32'd0);

        // back-to-back with valid held high
        lp0 = g_mon[0].ld_pulses;
        fc0 = int'(fc_a);
        push_exp(0, 16'h3FFC);
        push_exp(0, 16'h3000);
        drive(0, 12'h3FF, 1'b0, 1'b1);
        step();
        drive(0, 12'h000, 1'b0, 1'b1);
        chk("b2b_busy_during_frame", 32'(busy_a), 32'd1);
        t = 1;
        while (!rdy_of(0) && t < 200) begin
            step();
            t++;
        end
        chk("b2b_second_accept_cycle", 32'(t), 32'd71);
        step();
        drive(0, 12'h000, 1'b0, 1'b0);
        chk("b2b_second_cs_low", 32'(cs_a), 32'd0);
        wait_ready(0, 200);
        chk("b2b_ldac_pulses", 32'(g_mon[0].ld_pulses - lp0), 32'd2);
        chk("b2b_frame_cnt_delta", 32'(int'(fc_a) - fc0), 32'd2);
        chk("b2b_dac_out_zero", 32'(g_mon[0].dac_out), 32'h000);

        // shutdown frame still pulses LDAC
        lp0 = g_mon[0].ld_pulses;
        timed_frame(0, 12'h155, 1'b1, 16'h2554, 2, 2);
        chk("shdn_ldac_pulse", 32'(g_mon[0].ld_pulses - lp0), 32'd1);
        chk("shdn_dac_state", 32'(g_mon[0].dac_shdn_st), 32'd1);
        chk("shdn_frame_cnt", 32'(fc_a), 32'd4);

        // abort during bit 7 (cycles T25..T28)
        lp0 = g_mon[0].ld_pulses;
        push_exp(0, 16'h0000);
        drive(0, 12'h0AA, 1'b0, 1'b1);
        step();
        drive(0, 12'h0AA, 1'b0, 1'b0);
        repeat (25) step();
        chk("abort_in_frame", 32'(cs_a), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", 32'(cs_a), 32'd1);
        chk("abort_sck", 32'(sck_a), 32'd0);
        chk("abort_sdi", 32'(sdi_a), 32'd0);
        chk("abort_ld_n", 32'(ld_a), 32'd1);
        chk("abort_ready", 32'(if_a.dac_ready), 32'd1);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("abort_no_ldac", 32'(g_mon[0].ld_pulses - lp0), 32'd0);
        chk("abort_frame_cnt", 32'(fc_a), 32'd0);
        timed_frame(0, 12'h1C3, 1'b0, 16'h370C, 2, 2);
        chk("post_abort_frame_cnt", 32'(fc_a), 32'd1);
        chk("post_abort_dac_out", 32'(g_mon[0].dac_out), 32'h1C3);

        // fast 12-bit instance and 4-bit counter wrap
        timed_frame(1, 12'hABC, 1'b0, 16'h3ABC, 1, 1);
        chk("b_dac_out_abc", 32'(g_mon[1].dac_out), 32'hABC);
        chk("b_frame_cnt_1", 32'(fc_b), 32'd1);
        d = 12'h000;
        for (int i = 1; i <= 15; i++) begin
            d = 12'($urandom_range(0, 4095));
            push_exp(1, 16'h3000 | {4'h0, d});
            drive(1, d, 1'b0, 1'b1);
            step();
            drive(1, d, 1'b0, 1'b0);
            chk("b_busy_after_accept", 32'(busy_b), 32'd1);
            wait_ready(1, 100);
            if (i == 14) chk("b_frame_cnt_15", 32'(fc_b), 32'd15);
        end
        chk("b_frame_cnt_wrap", 32'(fc_b), 32'd0);
        chk("b_ldac_pulses_16", 32'(g_mon[1].ld_pulses), 32'd16);
        chk("b_dac_out_last", 32'(g_mon[1].dac_out), 32'(d));

        repeat (5) step();
        chk("a_queue_drained", 32'(g_mon[0].exp_q.size()), 32'd0);
        chk("b_queue_drained", 32'(g_mon[1].exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
